simo_fifo: RTL and testbench
============================

Name: simo_fifo

Overview:
Single-input, multiple-output replay buffer. It is the distribution-side counterpart of miso_fifo in the sequential router.
- Accepts one DATA_WIDTH element per write cycle.
- On each pop, emits a lane vector of up to DATA_LENGTH elements toward the PE row; the lane count is set by precision mode.
- Entries are not freed on pop. A read-pointer reset replays the stored contents, which supports weight and activation reuse.

Parameters:
DEPTH, 32, number of stored elements; power of two, >= DATA_LENGTH.
DATA_WIDTH, 8, bits per element.
DATA_LENGTH, 8, number of output lanes; power of two, >= 4.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_nrst  input  1  reset, asynchronous, active-low.
i_clear  input  1  synchronous clear of all pointers.
i_write_en  input  1  write i_data at the write pointer.
i_data  input  DATA_WIDTH  element to store.
i_pop_en  input  1  request one lane-vector read.
i_r_pointer_reset  input  1  rewind the read pointer to 0 (replay).
i_p_mode  input  2  precision mode; selects lanes per pop.
o_data  output  DATA_LENGTH x DATA_WIDTH  popped lane vector, registered.
o_valid  output  DATA_LENGTH  per-lane valid for o_data.
o_empty  output  1  no unread entries (rptr == wptr).
o_full  output  1  wptr == DEPTH.
o_pop_valid  output  1  o_data/o_valid carry a pop result this cycle.

Behaviour:
- Storage is a linear array mem[0..DEPTH-1].
  - wptr and rptr are each $clog2(DEPTH)+1 bits.
  - Writes do not wrap: once full, space is regained only through i_clear.
- Lanes per pop (L), by i_p_mode sampled in the pop cycle:
  - 00 -> DATA_LENGTH
  - 01 -> DATA_LENGTH/2
  - 10 -> DATA_LENGTH/4
  - 11 -> reserved, treated as 00
- Write: if i_write_en && !o_full, then mem[wptr] <= i_data and wptr <= wptr+1. A write while full is dropped silently; no state changes.
- Pop: if i_pop_en && !o_empty:
  - n = min(L, wptr - rptr), with wptr as it stood before this edge.
  - On the next cycle (1-cycle latency): o_data[k] = mem[rptr+k] for k < n, else 0; o_valid = (1<<n)-1; o_pop_valid = 1.
  - rptr <= rptr + n.
- Pop while empty: no effect. o_pop_valid = 0, o_valid = 0, o_data = 0.
- o_data, o_valid and o_pop_valid are registered. They hold pop results for exactly one cycle and return to 0 otherwise.
- Simultaneous write and pop: the pop sees only entries present before the edge. An element written in cycle t is poppable from cycle t+1.
- Priority, highest first:
  1. i_clear: wptr = rptr = 0; the write and pop in the same cycle are ignored; outputs go to 0 next cycle.
  2. i_r_pointer_reset: rptr = 0; a pop in the same cycle is ignored; a write in the same cycle proceeds.
  3. pop and write, which are independent of each other.
- o_empty = (rptr == wptr) and o_full = (wptr == DEPTH), both combinational from registered pointers. An i_clear or i_r_pointer_reset takes effect on these flags from the following cycle.
- Async reset (any time, including mid-pop): wptr = rptr = 0, o_data = 0, o_valid = 0, o_pop_valid = 0, so o_empty = 1 and o_full = 0. Memory contents are not reset; they are unreachable until rewritten.
- Changing i_p_mode between pops is legal; each pop uses the mode present in its own cycle.

Decomposition:
- Shared router package:
  - p_mode_t enum: P_8B = 2'b00, P_4B = 2'b01, P_2B = 2'b10.
  - Function lanes_per_pop(p_mode_t, DATA_LENGTH).
  - Pointer-width localparam derived via $clog2.
- One natural sub-module, simo_lane_gather: combinational. Given rptr, n and mem, it produces the lane vector and the valid mask. The top level holds pointers, storage and output registers.

Test Plan:
1. Mode 00; write 0x11, 0x22; pop -> next cycle o_pop_valid=1, o_valid=8'h03, o_data[0]=0x11, o_data[1]=0x22, lanes 2..7 = 0; o_empty=1; a second pop gives o_pop_valid=0.
2. i_clear; mode 01; write 0x01..0x05; pop x3 -> o_valid 8'h0F (lanes 0x01..0x04), then 8'h01 (lane0=0x05), then o_pop_valid=0.
3. i_clear; mode 10; write seven 0x01; pop x5 -> o_valid 8'h03, 8'h03, 8'h03, 8'h01, then no pop_valid.
4. After test 3 drains, pulse i_r_pointer_reset -> o_empty=0 next cycle; pop repeats the identical sequence. Pulsing pop together with r_pointer_reset -> no o_pop_valid.
5. Write 32 elements -> o_full=1; a 33rd write is dropped (wptr unchanged, data not overwritten); i_clear with concurrent write -> o_empty=1, o_full=0, nothing stored.
6. Write and pop in the same cycle on an empty FIFO -> no pop_valid; pop next cycle returns the element. Assert i_nrst low between pop and result -> o_pop_valid=0, o_data=0, o_empty=1 immediately.

Source files
------------

// File: rtl/simo_fifo_pkg.sv
// Shared definitions for the replay buffers: precision modes, lane counts
// and pointer sizing.
package simo_fifo_pkg;

  typedef enum logic [1:0] {
    P_8B = 2'b00,
    P_4B = 2'b01,
    P_2B = 2'b10
  } p_mode_t;

  localparam int DEFAULT_DEPTH = 32;
  localparam int DEFAULT_PTR_W = $clog2(DEFAULT_DEPTH) + 1;

  // Extra bit lets a pointer reach DEPTH itself, so full and empty are distinct.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The unlisted encoding 2'b11 falls through to the full lane count.
  function automatic int lanes_per_pop(input p_mode_t mode, input int data_length);
    case (mode)
      P_4B:    return data_length / 2;
      P_2B:    return data_length / 4;
      default: return data_length;
    endcase
  endfunction

endpackage

// File: rtl/simo_lane_gather.sv
// Combinational lane gather: picks `count` consecutive entries starting at
// rd_base and zero-fills the remaining lanes.
module simo_lane_gather
  import simo_fifo_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8
) (
  input  logic [$clog2(DEPTH)-1:0]           rd_base,
  input  logic [ptr_width(DEPTH)-1:0]        count,
  input  logic [DATA_WIDTH-1:0]              mem [DEPTH],
  output logic [DATA_LENGTH*DATA_WIDTH-1:0]  lanes,
  output logic [DATA_LENGTH-1:0]             valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_LENGTH; gi++) begin : g_lane
      localparam logic [PW-1:0] LANE_IDX  = PW'(gi);
      localparam logic [AW-1:0] LANE_ADDR = AW'(gi);
      logic [AW-1:0] addr;

      // Address may wrap for lanes beyond count; those lanes are masked to zero.
      assign addr      = rd_base + LANE_ADDR;
      assign valid[gi] = (LANE_IDX < count);
      assign lanes[gi*DATA_WIDTH +: DATA_WIDTH] = valid[gi] ? mem[addr] : '0;
    end
  endgenerate

endmodule

// File: rtl/simo_fifo.sv
// Single-input, multi-lane-output replay buffer. Pops do not free entries;
// rewinding the read pointer replays the stored contents.
module simo_fifo
  import simo_fifo_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_LENGTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_nrst,
  input  logic                               i_clear,
  input  logic                               i_write_en,
  input  logic [DATA_WIDTH-1:0]              i_data,
  input  logic                               i_pop_en,
  input  logic                               i_r_pointer_reset,
  input  logic [1:0]                         i_p_mode,
  output logic [DATA_LENGTH*DATA_WIDTH-1:0]  o_data,
  output logic [DATA_LENGTH-1:0]             o_valid,
  output logic                               o_empty,
  output logic                               o_full,
  output logic                               o_pop_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0]             mem [DEPTH];
  logic [PW-1:0]                     wptr_reg;
  logic [PW-1:0]                     rptr_reg;
  logic [PW-1:0]                     avail;
  logic [PW-1:0]                     lanes;
  logic [PW-1:0]                     n_next;
  logic [DATA_LENGTH*DATA_WIDTH-1:0] lane_data;
  logic [DATA_LENGTH-1:0]            lane_valid;
  logic                              write_fire;
  logic                              pop_fire;

  assign o_empty = (rptr_reg == wptr_reg);
  assign o_full  = (wptr_reg == PW'(DEPTH));

  always_comb begin
    avail      = wptr_reg - rptr_reg;
    lanes      = PW'(lanes_per_pop(p_mode_t'(i_p_mode), DATA_LENGTH));
    n_next     = (avail < lanes) ? avail : lanes;
    write_fire = i_write_en && !o_full && !i_clear;
    pop_fire   = i_pop_en && !o_empty && !i_clear && !i_r_pointer_reset;
  end

  // Storage has no reset: stale entries sit beyond wptr and are never read.
  always_ff @(posedge i_clk) begin
    if (write_fire) begin
      mem[wptr_reg[AW-1:0]] <= i_data;
    end
  end

  simo_lane_gather #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_LENGTH (DATA_LENGTH)
  ) u_gather (
    .rd_base (rptr_reg[AW-1:0]),
    .count   (n_next),
    .mem     (mem),
    .lanes   (lane_data),
    .valid   (lane_valid)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      o_data      <= '0;
      o_valid     <= '0;
      o_pop_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        wptr_reg <= '0;
        rptr_reg <= '0;
      end else begin
        if (write_fire) begin
          wptr_reg <= wptr_reg + 1'b1;
        end
        if (i_r_pointer_reset) begin
          rptr_reg <= '0;
        end else if (pop_fire) begin
          rptr_reg <= rptr_reg + n_next;
        end
      end
      // pop_fire already excludes clear and rewind, so outputs fall to zero then.
      o_pop_valid <= pop_fire;
      o_valid     <= pop_fire ? lane_valid : '0;
      o_data      <= pop_fire ? lane_data : '0;
    end
  end

endmodule

// File: tb/tb_simo_fifo.sv
// Directed bench for simo_fifo: write/pop/replay/clear/full/reset scenarios
// with hand-computed lane vectors.
module tb_simo_fifo;

  logic        i_clk;
  logic        i_nrst;
  logic        i_clear;
  logic        i_write_en;
  logic [7:0]  i_data;
  logic        i_pop_en;
  logic        i_r_pointer_reset;
  logic [1:0]  i_p_mode;
  logic [63:0] o_data;
  logic [7:0]  o_valid;
  logic        o_empty;
  logic        o_full;
  logic        o_pop_valid;

  int n_checks = 0;
  int n_fail   = 0;

  simo_fifo #(.DEPTH(32), .DATA_WIDTH(8), .DATA_LENGTH(8)) dut (
    .i_clk             (i_clk),
    .i_nrst            (i_nrst),
    .i_clear           (i_clear),
    .i_write_en        (i_write_en),
    .i_data            (i_data),
    .i_pop_en          (i_pop_en),
    .i_r_pointer_reset (i_r_pointer_reset),
    .i_p_mode          (i_p_mode),
    .o_data            (o_data),
    .o_valid           (o_valid),
    .o_empty           (o_empty),
    .o_full            (o_full),
    .o_pop_valid       (o_pop_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs set before step() are sampled at the next rising edge; outputs read 1ns later.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_elem(input logic [7:0] d);
    i_write_en = 1'b1;
    i_data     = d;
    step();
    i_write_en = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic pv, input logic [7:0] v, input logic [63:0] d);
    i_pop_en = 1'b1;
    step();
    i_pop_en = 1'b0;
    check({tag, ".pop_valid"}, 64'(o_pop_valid), 64'(pv));
    check({tag, ".valid"}, 64'(o_valid), 64'(v));
    check({tag, ".data"}, o_data, d);
  endtask

  task automatic clear_fifo();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
  endtask

  task automatic run_t3_pops(input string tag);
    pop_check({tag, ".p1"}, 1'b1, 8'h03, 64'h0101);
    pop_check({tag, ".p2"}, 1'b1, 8'h03, 64'h0101);
    pop_check({tag, ".p3"}, 1'b1, 8'h03, 64'h0101);
    pop_check({tag, ".p4"}, 1'b1, 8'h01, 64'h01);
    pop_check({tag, ".p5"}, 1'b0, 8'h00, 64'h0);
  endtask

  initial begin
    i_nrst = 1'b0; i_clear = 1'b0; i_write_en = 1'b0; i_data = '0;
    i_pop_en = 1'b0; i_r_pointer_reset = 1'b0; i_p_mode = 2'b00;
    #22;
    check("reset.empty", 64'(o_empty), 64'd1);
    check("reset.full", 64'(o_full), 64'd0);
    check("reset.pop_valid", 64'(o_pop_valid), 64'd0);
    check("reset.data", o_data, 64'h0);
    i_nrst = 1'b1;
    #1;

    // Test 1: mode 00, two entries, partial pop
    i_p_mode = 2'b00;
    write_elem(8'h11);
    write_elem(8'h22);
    pop_check("t1.p1", 1'b1, 8'h03, 64'h2211);
    check("t1.empty", 64'(o_empty), 64'd1);
    pop_check("t1.p2", 1'b0, 8'h00, 64'h0);

    // Test 2: mode 01, five entries
    clear_fifo();
    i_p_mode = 2'b01;
    for (int i = 1; i <= 5; i++) write_elem(8'(i));
    pop_check("t2.p1", 1'b1, 8'h0F, 64'h04030201);
    pop_check("t2.p2", 1'b1, 8'h01, 64'h05);
    pop_check("t2.p3", 1'b0, 8'h00, 64'h0);

    // Test 3: mode 10, seven entries
    clear_fifo();
    i_p_mode = 2'b10;
    for (int i = 0; i < 7; i++) write_elem(8'h01);
    run_t3_pops("t3");

    // Test 4: replay, then rewind combined with pop
    check("t4.empty_before", 64'(o_empty), 64'd1);
    i_r_pointer_reset = 1'b1;
    step();
    i_r_pointer_reset = 1'b0;
    check("t4.empty_after_rewind", 64'(o_empty), 64'd0);
    run_t3_pops("t4");
    i_r_pointer_reset = 1'b1;
    i_pop_en = 1'b1;
    step();
    i_r_pointer_reset = 1'b0;
    i_pop_en = 1'b0;
    check("t4.rewind_pop.pop_valid", 64'(o_pop_valid), 64'd0);
    check("t4.rewind_pop.empty", 64'(o_empty), 64'd0);

    // Test 5: full, dropped write, clear with concurrent write
    clear_fifo();
    i_p_mode = 2'b00;
    for (int i = 0; i < 32; i++) write_elem(8'(8'h40 + i));
    check("t5.full", 64'(o_full), 64'd1);
    write_elem(8'hEE);
    check("t5.full_after_drop", 64'(o_full), 64'd1);
    pop_check("t5.p1", 1'b1, 8'hFF, 64'h4746454443424140);
    pop_check("t5.p2", 1'b1, 8'hFF, 64'h4F4E4D4C4B4A4948);
    pop_check("t5.p3", 1'b1, 8'hFF, 64'h5756555453525150);
    pop_check("t5.p4", 1'b1, 8'hFF, 64'h5F5E5D5C5B5A5958);
    check("t5.drained_empty", 64'(o_empty), 64'd1);
    i_clear = 1'b1; i_write_en = 1'b1; i_data = 8'h99;
    step();
    i_clear = 1'b0; i_write_en = 1'b0;
    check("t5.clear.empty", 64'(o_empty), 64'd1);
    check("t5.clear.full", 64'(o_full), 64'd0);
    pop_check("t5.after_clear", 1'b0, 8'h00, 64'h0);

    // Test 6: simultaneous write+pop on empty, then reset mid-result; mode 11 acts as 00
    i_p_mode = 2'b11;
    i_write_en = 1'b1; i_data = 8'h77; i_pop_en = 1'b1;
    step();
    i_write_en = 1'b0; i_pop_en = 1'b0;
    check("t6.same_cycle.pop_valid", 64'(o_pop_valid), 64'd0);
    pop_check("t6.p1", 1'b1, 8'h01, 64'h77);
    write_elem(8'h88);
    i_pop_en = 1'b1;
    step();
    i_pop_en = 1'b0;
    check("t6.pre_reset.pop_valid", 64'(o_pop_valid), 64'd1);
    i_nrst = 1'b0;
    #1;
    check("t6.reset.pop_valid", 64'(o_pop_valid), 64'd0);
    check("t6.reset.data", o_data, 64'h0);
    check("t6.reset.empty", 64'(o_empty), 64'd1);
    check("t6.reset.full", 64'(o_full), 64'd0);
    #2;
    i_nrst = 1'b1;
    write_elem(8'h5A);
    pop_check("t6.post_reset", 1'b1, 8'h01, 64'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
